// File: rtl/config_loader_pkg.sv
// Shared types and sizing helpers for the configuration-chain loader.
package config_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    LOAD,
    DONE
  } state_e;

  function automatic int unsigned words_needed(input int unsigned chain_len,
                                               input int unsigned word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/config_word_serializer.sv
// Word-to-bit serializer: holds one word in a shifter, requests the next word
// while the last bit is still going out so a continuous stream has no bubble.
module config_word_serializer #(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned NUM_WORDS  = 19
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  init_i,
  input  logic                  active_i,
  input  logic                  last_shift_i,
  input  logic [WORD_WIDTH-1:0] word_i,
  input  logic                  word_valid_i,
  output logic                  word_ready_o,
  output logic                  bit_o,
  output logic                  enable_o
);

  localparam int unsigned BLW = $clog2(WORD_WIDTH + 1);
  localparam int unsigned WLW = $clog2(NUM_WORDS + 1);

  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic [BLW-1:0]        bits_left_q, bits_left_d;
  logic [WLW-1:0]        words_left_q, words_left_d;
  logic                  accept;

  always_comb begin
    enable_o     = (bits_left_q != '0);
    bit_o        = shreg_q[WORD_WIDTH-1];
    word_ready_o = active_i && (bits_left_q <= BLW'(1)) && (words_left_q != '0);
    accept       = word_valid_i && word_ready_o;

    shreg_d      = shreg_q;
    bits_left_d  = bits_left_q;
    words_left_d = words_left_q;

    if (init_i) begin
      shreg_d      = '0;
      bits_left_d  = '0;
      words_left_d = WLW'(NUM_WORDS);
    end else begin
      if (enable_o) begin
        shreg_d     = shreg_q << 1;
        bits_left_d = bits_left_q - BLW'(1);
      end
      // A fresh word overrides the shift that emits the previous word's last bit.
      if (accept) begin
        shreg_d      = word_i;
        bits_left_d  = BLW'(WORD_WIDTH);
        words_left_d = words_left_q - WLW'(1);
      end
      if (last_shift_i) begin
        bits_left_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg_q      <= '0;
      bits_left_q  <= '0;
      words_left_q <= '0;
    end else begin
      shreg_q      <= shreg_d;
      bits_left_q  <= bits_left_d;
      words_left_q <= words_left_d;
    end
  end

endmodule

// File: rtl/config_stream_loader.sv
// Clears the tile configuration chain, streams CHAIN_LENGTH bits into it and
// checks that only zeros fall out of the tail while loading.
module config_stream_loader
  import config_loader_pkg::*;
#(
  parameter int unsigned WORD_WIDTH   = 8,
  parameter int unsigned CHAIN_LENGTH = 146,
  parameter int unsigned CLEAR_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_out,
  output logic                  config_enable,
  output logic                  config_nreset,
  input  logic                  config_return,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned NUM_WORDS = words_needed(CHAIN_LENGTH, WORD_WIDTH);
  localparam int unsigned CW        = $clog2(CHAIN_LENGTH + 1);
  localparam int unsigned CCW       = $clog2(CLEAR_CYCLES + 1);

  state_e         state_q, state_d;
  logic [CCW-1:0] clr_cnt_q, clr_cnt_d;
  logic [CW-1:0]  bit_count_q, bit_count_d;
  logic           error_q, error_d;
  logic           start_ok;
  logic           last_shift;

  assign start_ok   = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_shift = config_enable && (bit_count_q == CW'(CHAIN_LENGTH - 1));

  config_word_serializer #(
    .WORD_WIDTH (WORD_WIDTH),
    .NUM_WORDS  (NUM_WORDS)
  ) u_serializer (
    .clk_i        (clock),
    .rst_i        (reset),
    .init_i       (start_ok),
    .active_i     (state_q == LOAD),
    .last_shift_i (last_shift),
    .word_i       (word_in),
    .word_valid_i (word_valid),
    .word_ready_o (word_ready),
    .bit_o        (config_out),
    .enable_o     (config_enable)
  );

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    bit_count_d = bit_count_q;
    error_d     = error_q;

    case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          state_d     = CLEAR;
          clr_cnt_d   = '0;
          bit_count_d = '0;
          error_d     = 1'b0;
        end
      end
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + CCW'(1);
        if (clr_cnt_q == CCW'(CLEAR_CYCLES - 1)) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        // The chain was cleared, so every bit leaving the tail must be zero.
        if (config_enable) begin
          bit_count_d = bit_count_q + CW'(1);
          if (config_return) begin
            error_d = 1'b1;
          end
        end
        if (last_shift) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      clr_cnt_q   <= '0;
      bit_count_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      bit_count_q <= bit_count_d;
      error_q     <= error_d;
    end
  end

  assign config_nreset = (state_q != CLEAR);
  assign busy          = (state_q == CLEAR) || (state_q == LOAD);
  assign done          = (state_q == DONE);
  assign error         = error_q;

endmodule

// File: tb/tb_config_stream_loader.sv
// Directed/randomized bench: a behavioural shift-register model of the tile chain
// is compared against the image formed by concatenating the words offered.
module tb_config_stream_loader;

  localparam int unsigned W   = 8;
  localparam int unsigned N   = 146;
  localparam int unsigned NW  = 19;
  localparam int unsigned NS  = 16;
  localparam int unsigned NWS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, valid;
  logic [W-1:0] win;
  logic         ready, cout, cen, cnrst, cret, busy, done, err;

  logic         start_s, valid_s;
  logic [W-1:0] win_s;
  logic         ready_s, cout_s, cen_s, cnrst_s, cret_s, busy_s, done_s, err_s;

  logic [N-1:0]  chain   = '0;
  logic [NS-1:0] chain_s = '0;
  logic          stuck   = 1'b0;

  logic [W-1:0] words   [NW];
  logic [W-1:0] words_s [NWS];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  config_stream_loader #(
    .WORD_WIDTH   (W),
    .CHAIN_LENGTH (N),
    .CLEAR_CYCLES (4)
  ) u_dut (
    .clock         (clk),
    .reset         (rst),
    .start         (start),
    .word_in       (win),
    .word_valid    (valid),
    .word_ready    (ready),
    .config_out    (cout),
    .config_enable (cen),
    .config_nreset (cnrst),
    .config_return (cret),
    .busy          (busy),
    .done          (done),
    .error         (err)
  );

  config_stream_loader #(
    .WORD_WIDTH   (W),
    .CHAIN_LENGTH (NS),
    .CLEAR_CYCLES (4)
  ) u_dut_s (
    .clock         (clk),
    .reset         (rst),
    .start         (start_s),
    .word_in       (win_s),
    .word_valid    (valid_s),
    .word_ready    (ready_s),
    .config_out    (cout_s),
    .config_enable (cen_s),
    .config_nreset (cnrst_s),
    .config_return (cret_s),
    .busy          (busy_s),
    .done          (done_s),
    .error         (err_s)
  );

  // Tile chain model: cleared by config_nreset, shifts config_out in at the head.
  always @(posedge clk) begin
    if (!cnrst) chain <= '0;
    else if (cen) chain <= {chain[N-2:0], cout};
    if (!cnrst_s) chain_s <= '0;
    else if (cen_s) chain_s <= {chain_s[NS-2:0], cout_s};
  end
  assign cret   = stuck | chain[N-1];
  assign cret_s = chain_s[NS-1];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic fill_words();
    for (int unsigned i = 0; i < NW; i++) words[i] = W'($urandom);
  endtask

  // First word lands deepest: image is the top N bits of all words concatenated.
  function automatic logic [N-1:0] exp_image();
    logic [NW*W-1:0] cat;
    for (int unsigned i = 0; i < NW; i++) cat[NW*W-1-i*W -: W] = words[i];
    return cat[NW*W-1 -: N];
  endfunction

  task automatic run_load(input bit rand_valid, input int unsigned rst_at, input bit poke_start,
                          output int unsigned shifts, output int unsigned nrst_cyc,
                          output int unsigned span, output int unsigned en_clear,
                          output logic err_first, output bit timed_out, output bit was_reset);
    int unsigned idx, first, last;
    bit got, poked;
    idx = 0; first = 0; last = 0; got = 0; poked = 0;
    shifts = 0; nrst_cyc = 0; en_clear = 0; err_first = 1'b0;
    timed_out = 1'b1; was_reset = 1'b0;
    @(negedge clk);
    start = 1'b1;
    valid = 1'b0;
    for (int unsigned c = 0; c < 3000; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (rst_at != 0 && shifts == rst_at) begin
        rst = 1'b1; valid = 1'b0; was_reset = 1'b1; timed_out = 1'b0;
        break;
      end
      if (shifts >= 1 && !got) begin err_first = err; got = 1'b1; end
      if (!cnrst) begin
        nrst_cyc++;
        if (cen) en_clear++;
      end else if (cen) begin
        if (shifts == 0) first = c;
        last = c;
        shifts++;
      end
      if (done) begin timed_out = 1'b0; break; end
      if (poke_start && shifts == 50 && !poked) begin start = 1'b1; poked = 1'b1; end
      valid = rand_valid ? 1'($urandom_range(0, 1)) : (idx < NW);
      win   = (idx < NW) ? words[idx] : W'($urandom);
      if (valid && ready) idx++;
    end
    valid = 1'b0;
    span  = (shifts != 0) ? (last - first + 1) : 0;
  endtask

  initial begin
    int unsigned sh, nr, sp, ec, idx, rdy_cnt, en_cnt;
    logic        ef;
    bit          to, wr;
    logic [N-1:0] img;

    rst = 1'b1; start = 1'b0; valid = 1'b0; win = '0;
    start_s = 1'b0; valid_s = 1'b0; win_s = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {ready, cout, cen, cnrst, busy, done, err}, 7'b0001000);
    chk("reset_outputs_s", {ready_s, cout_s, cen_s, cnrst_s, busy_s, done_s, err_s}, 7'b0001000);
    rst = 1'b0;
    @(negedge clk);

    // 1: continuous stream, low 6 bits of the final word must be discarded
    fill_words();
    words[NW-1][5:0] = 6'h3F;
    run_load(1'b0, 0, 1'b0, sh, nr, sp, ec, ef, to, wr);
    chk("t1_timeout", to, 0);
    chk("t1_nreset_cycles", nr, 4);
    chk("t1_enable_in_clear", ec, 0);
    chk("t1_shifts", sh, N);
    chk("t1_contiguous", sp, N);
    chk("t1_image", chain, exp_image());
    chk("t1_tail_bits", chain[1:0], words[NW-1][7:6]);
    chk("t1_status", {done, busy, err, ready}, 4'b1000);

    // 3: stuck-at-1 tail sets sticky error, done still reached
    fill_words();
    stuck = 1'b1;
    run_load(1'b0, 0, 1'b0, sh, nr, sp, ec, ef, to, wr);
    chk("t3_timeout", to, 0);
    chk("t3_err_after_first", ef, 1);
    chk("t3_done_err", {done, err}, 2'b11);
    chk("t3_shifts", sh, N);
    stuck = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("t3_err_cleared", {err, busy, cnrst}, 3'b010);

    // 2: random valid gaps (start inside CLEAR is ignored)
    fill_words();
    run_load(1'b1, 0, 1'b0, sh, nr, sp, ec, ef, to, wr);
    chk("t2_timeout", to, 0);
    chk("t2_shifts", sh, N);
    chk("t2_image", chain, exp_image());
    chk("t2_status", {done, err}, 2'b10);

    // 4: reset after 70 shifts, then a clean reload
    fill_words();
    run_load(1'b0, 70, 1'b0, sh, nr, sp, ec, ef, to, wr);
    chk("t4_reset_reached", wr, 1);
    @(negedge clk);
    chk("t4_reset_outputs", {ready, cout, cen, cnrst, busy, done, err}, 7'b0001000);
    rst = 1'b0;
    @(negedge clk);
    chk("t4_idle", {busy, done, cen}, 3'b000);
    fill_words();
    run_load(1'b0, 0, 1'b0, sh, nr, sp, ec, ef, to, wr);
    chk("t4_reload_shifts", sh, N);
    chk("t4_reload_nreset", nr, 4);
    chk("t4_reload_image", chain, exp_image());

    // 5: start during LOAD ignored; extra word after DONE refused
    fill_words();
    run_load(1'b0, 0, 1'b1, sh, nr, sp, ec, ef, to, wr);
    chk("t5_shifts", sh, N);
    chk("t5_contiguous", sp, N);
    chk("t5_nreset", nr, 4);
    img = exp_image();
    chk("t5_image", chain, img);
    rdy_cnt = 0; en_cnt = 0;
    valid = 1'b1; win = W'($urandom);
    for (int unsigned i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ready) rdy_cnt++;
      if (cen) en_cnt++;
    end
    valid = 1'b0;
    chk("t5_ready_in_done", rdy_cnt, 0);
    chk("t5_no_extra_shift", en_cnt, 0);
    chk("t5_image_held", chain, img);
    chk("t5_done_held", done, 1);

    // 6: exact multiple chain length, no discarded bits
    for (int unsigned i = 0; i < NWS; i++) words_s[i] = W'($urandom);
    @(negedge clk); start_s = 1'b1;
    idx = 0; sh = 0; nr = 0; to = 1'b1;
    for (int unsigned c = 0; c < 500; c++) begin
      @(negedge clk);
      start_s = 1'b0;
      if (!cnrst_s) nr++;
      else if (cen_s) sh++;
      if (done_s) begin to = 1'b0; break; end
      valid_s = (idx < NWS);
      win_s   = (idx < NWS) ? words_s[idx] : '0;
      if (valid_s && ready_s) idx++;
    end
    valid_s = 1'b0;
    chk("t6_timeout", to, 0);
    chk("t6_shifts", sh, NS);
    chk("t6_nreset", nr, 4);
    chk("t6_image", chain_s, {words_s[0], words_s[1]});
    chk("t6_status", {done_s, err_s, ready_s}, 3'b100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
